aes_decryptor: RTL

- Inverse-cipher counterpart of the AES-128 encryptor: turns 128-bit ciphertext blocks on an Avalon-ST stream back into plaintext, one key per message.
- Iterative datapath, one round per clock; the round-key schedule is expanded once per key into an 11-entry register bank.
- Sits on the receive side between the link deframer (msg_in) and the consumer (msg_out); key delivered over dvr_key_if.

---
 rtl/aes_decryptor.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_decryptor.sv
// AES-128 iterative inverse cipher on a 128-bit Avalon-ST stream; one round per clock,
// round keys expanded once per key into an 11-entry bank.
module aes_decryptor #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
  parameter int unsigned NUM_ROUNDS          = 10
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0]       key_in_key,
  input  logic                                   key_in_valid,
  output logic                                   key_in_rdy,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0]       msg_in_data,
  input  logic                                   msg_in_valid,
  output logic                                   msg_in_rdy,
  input  logic                                   msg_in_sop,
  input  logic                                   msg_in_eop,
  input  logic [$clog2(DATA_WIDTH_IN_BYTES)-1:0] msg_in_empty,
  output logic [8*DATA_WIDTH_IN_BYTES-1:0]       msg_out_data,
  output logic                                   msg_out_valid,
  input  logic                                   msg_out_rdy,
  output logic                                   msg_out_sop,
  output logic                                   msg_out_eop,
  output logic [$clog2(DATA_WIDTH_IN_BYTES)-1:0] msg_out_empty,
  output logic                                   busy
);

  localparam int unsigned DW = 8 * DATA_WIDTH_IN_BYTES;
  localparam int unsigned EW = $clog2(DATA_WIDTH_IN_BYTES);
  localparam int unsigned RW = $clog2(NUM_ROUNDS + 1);

  if (DATA_WIDTH_IN_BYTES != 16 || NUM_ROUNDS != 10) begin : g_param_check
    $error("aes_decryptor supports only DATA_WIDTH_IN_BYTES=16 and NUM_ROUNDS=10");
  end

  typedef logic [DW-1:0] blk_t;
  typedef enum logic [2:0] {IDLE, KEY_EXPAND, WAIT_BLOCK, DECRYPT, OUTPUT} state_t;

  // GF(2^8) arithmetic; S-boxes are derived from the field inverse instead of tables.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 equals a^-1 for nonzero a and maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  // Bit position of the MSB of byte i; byte 0 sits at the top of the block.
  function automatic int unsigned bpos(input int unsigned i);
    return DW - 1 - 8 * i;
  endfunction

  function automatic blk_t inv_shift_rows(input blk_t s);
    blk_t o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[bpos(r + 4*c) -: 8] = s[bpos(r + 4*((c + 4 - r) % 4)) -: 8];
    return o;
  endfunction

  function automatic blk_t inv_sub_bytes(input blk_t s);
    blk_t o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) o[bpos(i) -: 8] = inv_sbox(s[bpos(i) -: 8]);
    return o;
  endfunction

  function automatic blk_t inv_mix_columns(input blk_t s);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[bpos(4*c) -: 8];
      a1 = s[bpos(4*c + 1) -: 8];
      a2 = s[bpos(4*c + 2) -: 8];
      a3 = s[bpos(4*c + 3) -: 8];
      o[bpos(4*c) -: 8]     = gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3);
      o[bpos(4*c + 1) -: 8] = gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3);
      o[bpos(4*c + 2) -: 8] = gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3);
      o[bpos(4*c + 3) -: 8] = gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon_table(input logic [RW-1:0] i);
    case (i)
      RW'(0): return 8'h01;
      RW'(1): return 8'h02;
      RW'(2): return 8'h04;
      RW'(3): return 8'h08;
      RW'(4): return 8'h10;
      RW'(5): return 8'h20;
      RW'(6): return 8'h40;
      RW'(7): return 8'h80;
      RW'(8): return 8'h1b;
      RW'(9): return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic blk_t key_expand(input blk_t prev, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = prev;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t        state, state_next;
  logic [RW-1:0] rcnt;
  blk_t          rk [NUM_ROUNDS+1];
  blk_t          st;
  logic          sop_l, eop_l;
  logic [EW-1:0] empty_l;
  logic          key_take, blk_take, expand_step, round_step, final_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state and datapath strobes; handshakes use the registered ready/valid.
  always_comb begin
    state_next  = state;
    key_take    = 1'b0;
    blk_take    = 1'b0;
    expand_step = 1'b0;
    round_step  = 1'b0;
    final_step  = 1'b0;
    case (state)
      IDLE: if (key_in_valid && key_in_rdy) begin
        key_take   = 1'b1;
        state_next = KEY_EXPAND;
      end
      KEY_EXPAND: begin
        expand_step = 1'b1;
        if (rcnt == RW'(NUM_ROUNDS)) state_next = WAIT_BLOCK;
      end
      WAIT_BLOCK: if (msg_in_valid && msg_in_rdy) begin
        blk_take   = 1'b1;
        state_next = DECRYPT;
      end
      DECRYPT: begin
        if (rcnt == '0) begin
          final_step = 1'b1;
          state_next = OUTPUT;
        end else begin
          round_step = 1'b1;
        end
      end
      OUTPUT: if (msg_out_valid && msg_out_rdy) state_next = msg_out_eop ? IDLE : WAIT_BLOCK;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt          <= '0;
      st            <= '0;
      sop_l         <= 1'b0;
      eop_l         <= 1'b0;
      empty_l       <= '0;
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
      key_in_rdy    <= 1'b0;
      msg_in_rdy    <= 1'b0;
      msg_out_valid <= 1'b0;
      msg_out_data  <= '0;
      msg_out_sop   <= 1'b0;
      msg_out_eop   <= 1'b0;
      msg_out_empty <= '0;
      busy          <= 1'b0;
    end else begin
      if (key_take) begin
        rk[0] <= key_in_key;
        rcnt  <= RW'(1);
      end
      if (expand_step) begin
        rk[rcnt] <= key_expand(rk[RW'(rcnt - RW'(1))], rcon_table(RW'(rcnt - RW'(1))));
        rcnt     <= RW'(rcnt + RW'(1));
      end
      if (blk_take) begin
        st      <= msg_in_data ^ rk[NUM_ROUNDS];
        sop_l   <= msg_in_sop;
        eop_l   <= msg_in_eop;
        empty_l <= msg_in_empty;
        rcnt    <= RW'(NUM_ROUNDS - 1);
      end
      if (round_step) begin
        st   <= inv_mix_columns(inv_sub_bytes(inv_shift_rows(st)) ^ rk[rcnt]);
        rcnt <= RW'(rcnt - RW'(1));
      end
      if (final_step) begin
        msg_out_data  <= inv_sub_bytes(inv_shift_rows(st)) ^ rk[0];
        msg_out_sop   <= sop_l;
        msg_out_eop   <= eop_l;
        msg_out_empty <= empty_l;
      end
      key_in_rdy    <= (state_next == IDLE);
      msg_in_rdy    <= (state_next == WAIT_BLOCK);
      msg_out_valid <= (state_next == OUTPUT);
      busy          <= (state_next != IDLE);
    end
  end

endmodule
